// File: rtl/orbtrace_frame_pkg.sv
// Shared types and constants for the frame drain path between the packet
// buffer and the byte-wide host link.
package orbtrace_frame_pkg;

   localparam int FRAME_BYTES = 16;
   localparam int FRAME_W     = 128;

   localparam logic [FRAME_W-1:0] DEFAULT_SYNC_PATTERN =
      128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_7FFFFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      SYNC = 2'd2
   } state_e;

endpackage

// File: rtl/frame_serialiser.sv
// Holds one 128-bit frame and hands it out LSB byte first on a valid/ready
// stream; done pulses in the cycle the final byte is accepted.
module frame_serialiser
   import orbtrace_frame_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [FRAME_W-1:0] load_data,
   input  logic               byte_ready,
   output logic [7:0]         byte_out,
   output logic               byte_valid,
   output logic               done
);

   localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

   logic [FRAME_W-1:0] shift_q, shift_d;
   logic [3:0]         idx_q, idx_d;
   logic               valid_q, valid_d;
   logic               accept;

   // The register shifts right on every accepted byte, so the current byte
   // always sits in the bottom lane and stays put while stalled.
   always_comb begin
      accept  = valid_q & byte_ready;
      shift_d = shift_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      if (load) begin
         shift_d = load_data;
         idx_d   = 4'd0;
         valid_d = 1'b1;
      end else if (accept) begin
         shift_d = {8'h00, shift_q[FRAME_W-1:8]};
         idx_d   = idx_q + 4'd1;
         if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= '0;
         idx_q   <= 4'd0;
         valid_q <= 1'b0;
      end else begin
         shift_q <= shift_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end

   assign byte_out   = shift_q[7:0];
   assign byte_valid = valid_q & ~rst;
   assign done       = accept && (idx_q == LAST_IDX);

endmodule

// File: rtl/frame_scheduler.sv
// Drains frames from the packet buffer onto the host byte link, inserting
// sync frames on enable, every SYNC_INTERVAL data frames and after idle gaps.
module frame_scheduler
   import orbtrace_frame_pkg::*;
#(
   parameter int                 SYNC_INTERVAL    = 64,
   parameter int                 IDLE_SYNC_CYCLES = 65535,
   parameter logic [FRAME_W-1:0] SYNC_PATTERN     = DEFAULT_SYNC_PATTERN
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               Enable,
   input  logic [FRAME_W-1:0] Frame,
   input  logic               FrameReady,
   output logic               FrameNext,
   input  logic               DataOverf,
   output logic [7:0]         ByteOut,
   output logic               ByteValid,
   input  logic               ByteReady,
   output logic [15:0]        FrameCount,
   output logic [7:0]         OverfCount,
   output logic               Busy
);

   localparam logic [15:0] SYNC_INTERVAL_W = 16'(SYNC_INTERVAL);
   localparam logic [15:0] IDLE_SYNC_W     = 16'(IDLE_SYNC_CYCLES);

   state_e      state_q, state_d;
   logic        frame_next_q, frame_next_d;
   logic        busy_q, busy_d;
   logic [15:0] frame_count_q, frame_count_d;
   logic [7:0]  overf_count_q, overf_count_d;
   logic [15:0] idle_cnt_q, idle_cnt_d;
   logic [15:0] frames_since_sync_q, frames_since_sync_d;
   logic        sync_pending_q, sync_pending_d;
   logic        enable_hist_q, overf_hist_q;

   logic               enable_rise, overf_rise;
   logic               start_sync, start_data, idle_tick;
   logic               data_done, sync_done;
   logic               ser_load, ser_done;
   logic [FRAME_W-1:0] ser_data;

   // An Enable rising edge is folded straight into the IDLE decision so a
   // frame that is ready in the same cycle waits behind the sync frame.
   always_comb begin
      enable_rise = Enable & ~enable_hist_q;
      overf_rise  = DataOverf & ~overf_hist_q;
      state_d     = state_q;
      start_sync  = 1'b0;
      start_data  = 1'b0;
      idle_tick   = 1'b0;
      case (state_q)
         IDLE: begin
            if (Enable) begin
               if (sync_pending_q || enable_rise) begin
                  start_sync = 1'b1;
                  state_d    = SYNC;
               end else if (FrameReady) begin
                  start_data = 1'b1;
                  state_d    = SEND;
               end else begin
                  idle_tick = 1'b1;
               end
            end
         end
         SEND, SYNC: begin
            if (ser_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      data_done     = ser_done && (state_q == SEND);
      sync_done     = ser_done && (state_q == SYNC);
      frame_next_d  = start_data;
      busy_d        = (state_d != IDLE);
      frame_count_d = frame_count_q;
      if (data_done) begin
         frame_count_d = frame_count_q + 16'd1;
      end
      overf_count_d = overf_count_q;
      if (overf_rise && (overf_count_q != 8'hFF)) begin
         overf_count_d = overf_count_q + 8'd1;
      end
      frames_since_sync_d = frames_since_sync_q;
      if (sync_done) begin
         frames_since_sync_d = 16'd0;
      end else if (data_done) begin
         frames_since_sync_d = frames_since_sync_q + 16'd1;
      end
      idle_cnt_d = idle_cnt_q;
      if ((state_q == IDLE) && !Enable) begin
         idle_cnt_d = 16'd0;
      end else if (idle_tick) begin
         if (idle_cnt_q != 16'hFFFF) begin
            idle_cnt_d = idle_cnt_q + 16'd1;
         end
      end else if (ser_done) begin
         idle_cnt_d = 16'd0;
      end
      sync_pending_d = sync_pending_q;
      if (enable_rise
          || (data_done && (frames_since_sync_d >= SYNC_INTERVAL_W))
          || (idle_tick && (idle_cnt_d == IDLE_SYNC_W))) begin
         sync_pending_d = 1'b1;
      end
      if (start_sync) begin
         sync_pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q             <= IDLE;
         frame_next_q        <= 1'b0;
         busy_q              <= 1'b0;
         frame_count_q       <= 16'd0;
         overf_count_q       <= 8'd0;
         idle_cnt_q          <= 16'd0;
         frames_since_sync_q <= 16'd0;
         sync_pending_q      <= 1'b0;
         enable_hist_q       <= 1'b0;
         overf_hist_q        <= 1'b0;
      end else begin
         state_q             <= state_d;
         frame_next_q        <= frame_next_d;
         busy_q              <= busy_d;
         frame_count_q       <= frame_count_d;
         overf_count_q       <= overf_count_d;
         idle_cnt_q          <= idle_cnt_d;
         frames_since_sync_q <= frames_since_sync_d;
         sync_pending_q      <= sync_pending_d;
         enable_hist_q       <= Enable;
         overf_hist_q        <= DataOverf;
      end
   end

   assign ser_load = start_sync | start_data;
   assign ser_data = start_sync ? SYNC_PATTERN : Frame;

   frame_serialiser u_serialiser (
      .clk        (clk),
      .rst        (rst),
      .load       (ser_load),
      .load_data  (ser_data),
      .byte_ready (ByteReady),
      .byte_out   (ByteOut),
      .byte_valid (ByteValid),
      .done       (ser_done)
   );

   assign FrameNext  = frame_next_q;
   assign FrameCount = frame_count_q;
   assign OverfCount = overf_count_q;
   assign Busy       = busy_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: expected bytes are queued as frames
// are offered and compared as the link accepts them.
module tb_frame_scheduler;

   localparam int           SYNC_INTERVAL    = 2;
   localparam int           IDLE_SYNC_CYCLES = 10;
   localparam logic [127:0] SYNC_PAT = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_7FFFFFFF;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         Enable = 1'b0;
   logic [127:0] Frame = '0;
   logic         FrameReady = 1'b0;
   logic         FrameNext;
   logic         DataOverf = 1'b0;
   logic [7:0]   ByteOut;
   logic         ByteValid;
   logic         ByteReady = 1'b1;
   logic [15:0]  FrameCount;
   logic [7:0]   OverfCount;
   logic         Busy;

   int           check_count = 0;
   int           error_count = 0;
   int           fn_count = 0;
   logic [7:0]   exp_q[$];
   logic [127:0] buf_q[$];

   frame_scheduler #(
      .SYNC_INTERVAL    (SYNC_INTERVAL),
      .IDLE_SYNC_CYCLES (IDLE_SYNC_CYCLES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .Enable     (Enable),
      .Frame      (Frame),
      .FrameReady (FrameReady),
      .FrameNext  (FrameNext),
      .DataOverf  (DataOverf),
      .ByteOut    (ByteOut),
      .ByteValid  (ByteValid),
      .ByteReady  (ByteReady),
      .FrameCount (FrameCount),
      .OverfCount (OverfCount),
      .Busy       (Busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_count++;
      if (obs !== exp) begin
         error_count++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] make_frame(input logic [7:0] base);
      logic [127:0] f;
      for (int i = 0; i < 16; i++) f[i*8 +: 8] = base + 8'(i);
      return f;
   endfunction

   task automatic push_sync();
      logic [127:0] pat;
      pat = SYNC_PAT;
      for (int i = 0; i < 16; i++) exp_q.push_back(pat[i*8 +: 8]);
   endtask

   // Offers a frame to the buffer model and queues the bytes it should produce.
   task automatic applyStimulus(input logic [127:0] f, input int nbytes);
      buf_q.push_back(f);
      for (int i = 0; i < nbytes; i++) exp_q.push_back(f[i*8 +: 8]);
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
   endtask

   task automatic measure_gap(input string tag);
      int gap;
      gap = 0;
      while (gap < 100) begin
         @(negedge clk);
         #1;
         if (Busy) break;
         gap++;
      end
      checkOutput(tag, 32'(gap), 32'd11);
   endtask

   task automatic pulse_overf(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1; DataOverf = 1'b1;
         @(posedge clk); #1; DataOverf = 1'b0;
      end
   endtask

   // Packet buffer model: pops on FrameNext, presents the head frame.
   always @(posedge clk) begin
      if (FrameNext === 1'b1 && buf_q.size() > 0) void'(buf_q.pop_front());
      #2;
      if (buf_q.size() > 0) begin
         Frame      = buf_q[0];
         FrameReady = 1'b1;
      end else begin
         FrameReady = 1'b0;
      end
   end

   // Link-side monitor: scoreboard compare, stall stability, pulse shape.
   logic       stalled = 1'b0;
   logic [7:0] stall_byte = 8'h00;
   logic       prev_fn = 1'b0;
   logic       idle_chk = 1'b0;
   int         acc_cnt = 0;

   always @(negedge clk) begin
      if (rst) begin
         stalled  = 1'b0;
         prev_fn  = 1'b0;
         idle_chk = 1'b0;
         acc_cnt  = 0;
      end else begin
         if (idle_chk) begin
            checkOutput("busy_after_frame", 32'(Busy), 32'd0);
            idle_chk = 1'b0;
         end
         if (stalled && ByteValid) checkOutput("stall_stable", 32'(ByteOut), 32'(stall_byte));
         stalled = 1'b0;
         if (FrameNext) begin
            fn_count++;
            checkOutput("fn_with_valid", 32'(ByteValid), 32'd1);
            checkOutput("fn_single", 32'(prev_fn), 32'd0);
         end
         prev_fn = FrameNext;
         if (ByteValid && ByteReady) begin
            if (exp_q.size() == 0) checkOutput("byte_expected", 32'(exp_q.size()), 32'd1);
            else checkOutput("byte", 32'(ByteOut), 32'(exp_q.pop_front()));
            acc_cnt++;
            if (acc_cnt == 16) begin
               acc_cnt  = 0;
               idle_chk = 1'b1;
            end
         end else if (ByteValid) begin
            stalled    = 1'b1;
            stall_byte = ByteOut;
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cycles;
      int w;
      int fn0;
      Enable    = 1'b1;
      ByteReady = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_fn", 32'(FrameNext), 32'd0);
      checkOutput("rst_valid", 32'(ByteValid), 32'd0);
      checkOutput("rst_byte", 32'(ByteOut), 32'd0);
      checkOutput("rst_fcount", 32'(FrameCount), 32'd0);
      checkOutput("rst_ocount", 32'(OverfCount), 32'd0);
      checkOutput("rst_busy", 32'(Busy), 32'd0);

      $display("[TB] sync after reset release with Enable high");
      push_sync();
      rst = 1'b0;
      wait_drain(100);
      checkOutput("sync_no_fn", 32'(fn_count), 32'd0);
      checkOutput("sync_fcount", 32'(FrameCount), 32'd0);

      $display("[TB] single data frame then idle syncs");
      @(posedge clk); #1;
      applyStimulus(128'h0F0E0D0C_0B0A0908_07060504_03020100, 16);
      wait_drain(100);
      push_sync();
      measure_gap("idle_gap1");
      checkOutput("fcount_a", 32'(FrameCount), 32'd1);
      checkOutput("fn_a", 32'(fn_count), 32'd1);
      wait_drain(100);
      push_sync();
      measure_gap("idle_gap2");
      wait_drain(100);

      $display("[TB] ByteReady toggling");
      @(posedge clk); #1;
      ByteReady = 1'b0;
      applyStimulus(make_frame(8'h40), 16);
      w = 0;
      while (!Busy && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      checkOutput("stall_start", 32'(Busy), 32'd1);
      cycles = 0;
      do begin
         cycles++;
         @(posedge clk); #1;
         ByteReady = ~ByteReady;
      end while (Busy && cycles < 100);
      checkOutput("stall_cycles", 32'(cycles), 32'd32);
      ByteReady = 1'b1;

      $display("[TB] sync interval with five queued frames");
      fn0 = fn_count;
      applyStimulus(make_frame(8'h80), 16);
      push_sync();
      applyStimulus(make_frame(8'h90), 16);
      applyStimulus(make_frame(8'hA0), 16);
      push_sync();
      applyStimulus(make_frame(8'hB0), 16);
      applyStimulus(make_frame(8'hC0), 16);
      push_sync();
      wait_drain(400);
      checkOutput("interval_fn", 32'(fn_count - fn0), 32'd5);
      checkOutput("fcount_7", 32'(FrameCount), 32'd7);
      @(posedge clk); #1;
      Enable = 1'b0;

      $display("[TB] overflow counting");
      pulse_overf(100);
      checkOutput("ocount_100", 32'(OverfCount), 32'd100);
      pulse_overf(200);
      checkOutput("ocount_sat", 32'(OverfCount), 32'd255);
      checkOutput("disabled_no_bytes", 32'(exp_q.size()), 32'd0);

      $display("[TB] enable with frame ready, reset mid-frame");
      push_sync();
      applyStimulus(make_frame(8'h70), 7);
      repeat (2) @(posedge clk);
      #1;
      Enable = 1'b1;
      wait_drain(200);
      @(posedge clk); #1;
      checkOutput("byte7_valid", 32'(ByteValid), 32'd1);
      checkOutput("byte7_value", 32'(ByteOut), 32'h77);
      rst = 1'b1;
      #1;
      checkOutput("midrst_valid", 32'(ByteValid), 32'd0);
      checkOutput("midrst_busy", 32'(Busy), 32'd0);
      checkOutput("midrst_fcount", 32'(FrameCount), 32'd0);
      checkOutput("midrst_ocount", 32'(OverfCount), 32'd0);
      checkOutput("midrst_byte", 32'(ByteOut), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      fn0 = fn_count;
      push_sync();
      rst = 1'b0;
      wait_drain(100);
      checkOutput("post_rst_fn", 32'(fn_count - fn0), 32'd0);
      checkOutput("post_rst_fcount", 32'(FrameCount), 32'd0);
      @(posedge clk); #1;
      Enable = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("final_idle", 32'(Busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
